// File: rtl/uart_pkg.sv
// Shared state encoding, parity modes and width helper for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5,
        ST_BREAK  = 3'd6
    } state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering producer words ahead of the UART serialiser.
// Count-based registered full/empty flags; DEPTH must be a power of two.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_d;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop)
            count_d = count + (AW+1)'(1);
        else if (do_pop && !do_push)
            count_d = count - (AW+1)'(1);
    end

    // NOTE: storage is deliberately not reset; the empty flag keeps stale entries from being used.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == (AW+1)'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered, LSB-first, runtime parity and stop-bit selection.
// Break generation (brk port, BREAK state) is built only when UART_TX_BREAK_EN is defined.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 b_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 fifo_empty
);
    localparam int TICK_W = cnt_w(OVERSAMPLE);
    localparam int BIT_W  = cnt_w(DATA_BITS + 4);
`ifdef UART_TX_BREAK_EN
    localparam int BRK_MAX = DATA_BITS + 3;
`endif

    state_t               state, state_d;
    logic [TICK_W-1:0]    tick_cnt, tick_d;
    logic [BIT_W-1:0]     bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shift, shift_d, fifo_rdata;
    logic                 par_bit, par_d, par_en_q, par_en_d, two_stop_q, two_stop_d;
    logic                 stop_cnt, stop_cnt_d, tx_d;
    logic                 fifo_pop, fifo_full, bit_end, load;

    uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign tx_busy  = (state != ST_IDLE);
    assign bit_end  = b_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        tick_d     = tick_cnt;
        bit_d      = bit_cnt;
        shift_d    = shift;
        par_d      = par_bit;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        stop_cnt_d = (state == ST_STOP) ? stop_cnt : 1'b0;
        load       = 1'b0;
        if (b_tick)
            tick_d = bit_end ? '0 : tick_cnt + TICK_W'(1);

        unique case (state)
            ST_IDLE: begin
                tick_d = '0;
`ifdef UART_TX_BREAK_EN
                if (brk) begin
                    state_d    = ST_BREAK;
                    bit_d      = '0;
                    par_en_d   = parity_en;
                    two_stop_d = 1'b0;
                end else
`endif
                if (!fifo_empty)
                    load = 1'b1;
            end
            ST_WAIT: begin
                tick_d = '0;
                if (b_tick) state_d = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift >> 1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1))
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    else
                        bit_d = bit_cnt + BIT_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop_cnt)
                        stop_cnt_d = 1'b1;
                    else if (!fifo_empty)
                        load = 1'b1;
                    else
                        state_d = ST_IDLE;
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                // bit_cnt counts completed break bit times, saturating once the minimum is met.
                if (bit_end) begin
                    if (int'(bit_cnt) < BRK_MAX)
                        bit_d = bit_cnt + BIT_W'(1);
                    if (!brk && (int'(bit_cnt) + 1 >= DATA_BITS + 2 + int'(par_en_q)))
                        state_d = ST_STOP;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Pop and latch the frame configuration; later config changes wait for the next frame.
        if (load) begin
            state_d    = ST_WAIT;
            shift_d    = fifo_rdata;
            par_d      = (parity_t'(parity_odd) == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
            par_en_d   = parity_en;
            two_stop_d = two_stop;
            stop_cnt_d = 1'b0;
        end
        fifo_pop = load;

        unique case (state_d)
            ST_START, ST_BREAK: tx_d = 1'b0;
            ST_DATA:            tx_d = shift_d[0];
            ST_PARITY:          tx_d = par_d;
            default:            tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b1;
        end else begin
            tick_cnt   <= tick_d;
            bit_cnt    <= bit_d;
            shift      <= shift_d;
            par_bit    <= par_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            stop_cnt   <= stop_cnt_d;
            tx         <= tx_d;
        end
    end

endmodule
